// File: rtl/fetch.sv
// fetch: bytecode fetch/issue stage feeding the control unit.
// Reads a byte-wide program memory that has a 1-cycle read latency and
// decodes the instruction length from the opcode. It assembles the opcode
// and its operand bytes and holds them stable while control executes.
// On op_done the pc moves to the next sequential opcode, or to
// pc + offset when the branch is taken.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous, active-high reset
//   mem_addr_o  program-memory byte address (combinational)
//   mem_data_i  byte at the address presented in the previous cycle
//   op_code_o   issued opcode, 8'h00 while op_valid_o = 0
//   arg1_o      first operand byte, 8'h00 if unused or not valid
//   arg2_o      second operand byte, 8'h00 if unused or not valid
//   op_valid_o  issued instruction is valid and held
//   op_done_i   one-cycle completion pulse from control
//   jump_i      taken branch, sampled with op_done_i
//   offset_i    signed branch offset relative to the opcode address
//   pc_o        address of the current or most recently fetched opcode
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | address the opcode byte at pc
// OP    | capture opcode and length, address pc+1
// A1    | capture arg1, address pc+2
// A2    | capture arg2
// EXEC  | instruction issued, wait for op_done
module fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        op_code_o,
  output logic [7:0]        arg1_o,
  output logic [7:0]        arg2_o,
  output logic              op_valid_o,
  input  logic              op_done_i,
  input  logic              jump_i,
  input  logic [15:0]       offset_i,
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic [2:0] {S_REQ, S_OP, S_A1, S_A2, S_EXEC} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [7:0]        opcode_q;
  logic [7:0]        arg1_q;
  logic [7:0]        arg2_q;
  logic [1:0]        len_q;
  logic [1:0]        len_d;
  logic              op_valid_q;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36)
      return 2'd2;
    else if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7))
      return 2'd3;
    else
      return 2'd1;
  endfunction

  assign len_d = op_len(mem_data_i);

  // The size cast sign-extends the 16-bit offset (or truncates it for
  // narrower pcs); the sum then wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q + ADDR_W'(len_q);
    if (jump_i)
      pc_d = pc_q + ADDR_W'($signed(offset_i));
  end

  always_comb begin
    mem_addr_o = pc_q;
    case (state_q)
      S_OP:    mem_addr_o = pc_q + ADDR_W'(1);
      S_A1:    mem_addr_o = pc_q + ADDR_W'(2);
      default: mem_addr_o = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= '0;
      opcode_q   <= '0;
      arg1_q     <= '0;
      arg2_q     <= '0;
      len_q      <= 2'd1;
      op_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: state_q <= S_OP;
        S_OP: begin
          opcode_q <= mem_data_i;
          len_q    <= len_d;
          arg1_q   <= '0;
          arg2_q   <= '0;
          if (len_d == 2'd1) begin
            state_q    <= S_EXEC;
            op_valid_q <= 1'b1;
          end else begin
            state_q <= S_A1;
          end
        end
        S_A1: begin
          arg1_q <= mem_data_i;
          if (len_q == 2'd2) begin
            state_q    <= S_EXEC;
            op_valid_q <= 1'b1;
          end else begin
            state_q <= S_A2;
          end
        end
        S_A2: begin
          arg2_q     <= mem_data_i;
          state_q    <= S_EXEC;
          op_valid_q <= 1'b1;
        end
        S_EXEC: begin
          if (op_done_i) begin
            pc_q       <= pc_d;
            op_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q    <= S_REQ;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign op_valid_o = op_valid_q;
  assign op_code_o  = op_valid_q ? opcode_q : 8'h00;
  assign arg1_o     = op_valid_q ? arg1_q   : 8'h00;
  assign arg2_o     = op_valid_q ? arg2_q   : 8'h00;
  assign pc_o       = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a byte array models the synchronous-read
// program memory; each task drives one scenario and checks inline.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  op_code;
  logic [7:0]  arg1;
  logic [7:0]  arg2;
  logic        op_valid;
  logic        op_done;
  logic        jump;
  logic [15:0] offset;
  logic [15:0] pc;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  fetch #(.ADDR_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .op_code_o  (op_code),
    .arg1_o     (arg1),
    .arg2_o     (arg2),
    .op_valid_o (op_valid),
    .op_done_i  (op_done),
    .jump_i     (jump),
    .offset_i   (offset),
    .pc_o       (pc)
  );

  // Called at a negedge inside a REQ cycle; returns cycles until op_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_valid && lat < 20);
  endtask

  // Waits dly cycles, then pulses op_done for one cycle; returns at a
  // negedge inside the following REQ cycle.
  task automatic complete(input int dly, input logic j, input logic [15:0] off);
    repeat (dly) @(negedge clk);
    op_done = 1'b1; jump = j; offset = off;
    @(negedge clk);
    op_done = 1'b0; jump = 1'b0; offset = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_done = 1'b0; jump = 1'b0; offset = 16'h0000;
    repeat (2) @(negedge clk);
    tests_run++; if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b exp 0", op_valid); end
    tests_run++; if ({op_code, arg1, arg2} !== 24'h000000) begin tests_failed++; $display("FAIL rst_operands: got %h exp 000000", {op_code, arg1, arg2}); end
    tests_run++; if (pc !== 16'h0000) begin tests_failed++; $display("FAIL rst_pc: got %h exp 0000", pc); end
    tests_run++; if (mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_mem_addr: got %h exp 0000", mem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [7:0]  e_op  [3] = '{8'h02, 8'h10, 8'h60};
    logic [7:0]  e_a1  [3] = '{8'h00, 8'h05, 8'h00};
    logic [15:0] e_pc  [3] = '{16'd0, 16'd1, 16'd3};
    logic [15:0] e_nxt [3] = '{16'd1, 16'd3, 16'd4};
    int          e_lat [3] = '{2, 3, 2};
    int lat;
    for (int i = 0; i < 3; i++) begin
      wait_valid(lat);
      tests_run++; if (lat !== e_lat[i]) begin tests_failed++; $display("FAIL sl_latency[%0d]: got %0d exp %0d", i, lat, e_lat[i]); end
      tests_run++; if ({op_code, arg1, arg2} !== {e_op[i], e_a1[i], 8'h00}) begin tests_failed++; $display("FAIL sl_issue[%0d]: got %h exp %h", i, {op_code, arg1, arg2}, {e_op[i], e_a1[i], 8'h00}); end
      tests_run++; if (pc !== e_pc[i]) begin tests_failed++; $display("FAIL sl_pc[%0d]: got %h exp %h", i, pc, e_pc[i]); end
      tests_run++; if (mem_addr !== e_pc[i]) begin tests_failed++; $display("FAIL sl_exec_addr[%0d]: got %h exp %h", i, mem_addr, e_pc[i]); end
      complete(1, 1'b0, 16'h0000);
      tests_run++; if (op_valid !== 1'b0) begin tests_failed++; $display("FAIL sl_gap[%0d]: got %b exp 0", i, op_valid); end
      tests_run++; if (pc !== e_nxt[i]) begin tests_failed++; $display("FAIL sl_next_pc[%0d]: got %h exp %h", i, pc, e_nxt[i]); end
      tests_run++; if (mem_addr !== e_nxt[i]) begin tests_failed++; $display("FAIL sl_req_addr[%0d]: got %h exp %h", i, mem_addr, e_nxt[i]); end
    end
  endtask

  task automatic test_three_byte();
    int lat;
    wait_valid(lat);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL tb_latency: got %0d exp 4", lat); end
    tests_run++; if ({op_code, arg1, arg2} !== 24'h111234) begin tests_failed++; $display("FAIL tb_issue: got %h exp 111234", {op_code, arg1, arg2}); end
    tests_run++; if (pc !== 16'd4) begin tests_failed++; $display("FAIL tb_pc: got %h exp 0004", pc); end
    complete(1, 1'b0, 16'h0000);
    tests_run++; if (pc !== 16'd7) begin tests_failed++; $display("FAIL tb_next_pc: got %h exp 0007", pc); end
  endtask

  task automatic test_branch();
    int lat;
    wait_valid(lat);                       // nop at 7
    complete(1, 1'b0, 16'h0000);
    tests_run++; if (pc !== 16'd8) begin tests_failed++; $display("FAIL br_pre_pc: got %h exp 0008", pc); end
    wait_valid(lat);                       // goto at 8
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL br_latency: got %0d exp 4", lat); end
    tests_run++; if ({op_code, arg1, arg2} !== 24'hA7FFF8) begin tests_failed++; $display("FAIL br_issue: got %h exp a7fff8", {op_code, arg1, arg2}); end
    complete(1, 1'b1, 16'hFFF8);
    tests_run++; if (pc !== 16'd0) begin tests_failed++; $display("FAIL br_taken_pc: got %h exp 0000", pc); end
    wait_valid(lat);                       // op at 0, jump forward to 8
    tests_run++; if (op_code !== 8'h02) begin tests_failed++; $display("FAIL br_target_op: got %h exp 02", op_code); end
    complete(1, 1'b1, 16'h0008);
    tests_run++; if (pc !== 16'd8) begin tests_failed++; $display("FAIL br_fwd_pc: got %h exp 0008", pc); end
    wait_valid(lat);                       // goto at 8, not taken
    complete(1, 1'b0, 16'hFFF8);
    tests_run++; if (pc !== 16'd11) begin tests_failed++; $display("FAIL br_not_taken_pc: got %h exp 000b", pc); end
  endtask

  task automatic test_stall_hold();
    int lat;
    // op_done high (with jump) through REQ, OP, A1 and A2 must be ignored
    op_done = 1'b1; jump = 1'b1; offset = 16'h0100;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_valid && lat < 20);
    op_done = 1'b0; jump = 1'b0; offset = 16'h0000;
    tests_run++; if (pc !== 16'd11) begin tests_failed++; $display("FAIL sh_spurious_pc: got %h exp 000b", pc); end
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL sh_latency: got %0d exp 4", lat); end
    tests_run++; if ({op_code, arg1, arg2} !== 24'h11ABCD) begin tests_failed++; $display("FAIL sh_issue: got %h exp 11abcd", {op_code, arg1, arg2}); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++; if ({op_valid, op_code, arg1, arg2, pc} !== {1'b1, 24'h11ABCD, 16'd11}) begin tests_failed++; $display("FAIL sh_hold[%0d]: got %h exp %h", c, {op_valid, op_code, arg1, arg2, pc}, {1'b1, 24'h11ABCD, 16'd11}); end
    end
    complete(0, 1'b0, 16'h0000);
    tests_run++; if (pc !== 16'd14) begin tests_failed++; $display("FAIL sh_next_pc: got %h exp 000e", pc); end
  endtask

  task automatic test_wrap();
    logic [15:0] s_pc  [4] = '{16'h000E, 16'hFFFF, 16'h0000, 16'hFFFF};
    logic [7:0]  s_op  [4] = '{8'h00, 8'h60, 8'h02, 8'h60};
    logic        s_j   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] s_off [4] = '{16'hFFF1, 16'h0000, 16'hFFFF, 16'h0002};
    logic [15:0] s_nxt [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      tests_run++; if ({lat[7:0], op_code, pc} !== {8'd2, s_op[i], s_pc[i]}) begin tests_failed++; $display("FAIL wr_issue[%0d]: got lat %0d op %h pc %h exp lat 2 op %h pc %h", i, lat, op_code, pc, s_op[i], s_pc[i]); end
      complete(1, s_j[i], s_off[i]);
      tests_run++; if (pc !== s_nxt[i]) begin tests_failed++; $display("FAIL wr_next_pc[%0d]: got %h exp %h", i, pc, s_nxt[i]); end
    end
  endtask

  task automatic test_reset_exec();
    int lat;
    wait_valid(lat);                       // iload-style op at pc 1
    tests_run++; if ({op_code, arg1, pc} !== {8'h10, 8'h05, 16'd1}) begin tests_failed++; $display("FAIL re_issue: got %h exp 100500 01", {op_code, arg1, pc}); end
    rst = 1'b1; op_done = 1'b1; jump = 1'b1; offset = 16'h0040;
    @(negedge clk);
    tests_run++; if (pc !== 16'd0) begin tests_failed++; $display("FAIL re_pc: got %h exp 0000", pc); end
    tests_run++; if ({op_valid, op_code, arg1, arg2} !== 25'h0) begin tests_failed++; $display("FAIL re_outputs: got %h exp 0", {op_valid, op_code, arg1, arg2}); end
    tests_run++; if (mem_addr !== 16'd0) begin tests_failed++; $display("FAIL re_mem_addr: got %h exp 0000", mem_addr); end
    rst = 1'b0; op_done = 1'b0; jump = 1'b0; offset = 16'h0000;
    wait_valid(lat);
    tests_run++; if ({lat[7:0], op_code, pc} !== {8'd2, 8'h02, 16'd0}) begin tests_failed++; $display("FAIL re_restart: got lat %0d op %h pc %h exp lat 2 op 02 pc 0000", lat, op_code, pc); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[0]  = 8'h02;
    mem[1]  = 8'h10; mem[2]  = 8'h05;
    mem[3]  = 8'h60;
    mem[4]  = 8'h11; mem[5]  = 8'h12; mem[6]  = 8'h34;
    mem[7]  = 8'h00;
    mem[8]  = 8'hA7; mem[9]  = 8'hFF; mem[10] = 8'hF8;
    mem[11] = 8'h11; mem[12] = 8'hAB; mem[13] = 8'hCD;
    mem[14] = 8'h00;
    mem[16'hFFFF] = 8'h60;

    test_reset();
    test_straight_line();
    test_three_byte();
    test_branch();
    test_stall_hold();
    test_wrap();
    test_reset_exec();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch.md
# fetch

Bytecode fetch/issue stage sitting directly upstream of `control`. It reads the method bytecode from a byte-wide synchronous-read program memory, decodes the instruction length from the opcode, assembles `op_code`/`arg1`/`arg2`, holds them stable while `control` executes, and advances the program counter on `op_done`. The PC advances either sequentially or by the signed `offset` that `control` returns for taken branches.

## Interface

- `ADDR_W`, 16: program-memory address width and PC width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_addr` output ADDR_W: program-memory byte address, combinational from state and PC.
- `mem_data` input 8: byte at the `mem_addr` presented in the previous cycle (1-cycle read latency).
- `op_code` output 8: opcode issued to `control`. Reads 8'h00 (nop) whenever `op_valid`=0.
- `arg1` output 8: first operand byte. 8'h00 if unused or `op_valid`=0.
- `arg2` output 8: second operand byte. 8'h00 if unused or `op_valid`=0.
- `op_valid` output 1: the issued instruction is valid and held stable.
- `op_done` input 1: single-cycle pulse from `control` when the instruction has completed.
- `jump` input 1: sampled with `op_done`. 1 means a taken branch.
- `offset` input 16: signed branch offset, relative to the opcode address; sampled with `op_done`.
- `pc` output ADDR_W: address of the current or most recently fetched opcode.

## Operation

- **Length decode** (from opcode):
  - 2 bytes: 8'h10 bipush, 8'h12 ldc, 8'h15 iload, 8'h36 istore.
  - 3 bytes: 8'h11 sipush, 8'h84 iinc, 8'h99–8'hA7 if*/goto.
  - 1 byte: every other opcode.
- **FSM states:**
  - **REQ:** `mem_addr`=pc. Next state is OP.
  - **OP:** capture `mem_data` into the opcode register and latch len. `mem_addr`=pc+1. Clear the arg registers. If len=1, go to EXEC; else go to A1.
  - **A1:** capture `mem_data` into arg1. `mem_addr`=pc+2. If len=2, go to EXEC; else go to A2.
  - **A2:** capture `mem_data` into arg2. Go to EXEC.
  - **EXEC:** `op_valid`=1 and registered values are driven on the outputs. `mem_addr`=pc. Stay until `op_done`=1.
    - On `op_done`: pc ← pc + sign-extended `offset` if `jump`, else pc + len. Go to REQ.
- **Arithmetic:** all PC arithmetic is modulo 2^ADDR_W. Wrap from 16'hFFFF to 16'h0000 is legal and silent. For ADDR_W<16, `offset` is truncated after sign extension.
- `jump` and `offset` are ignored unless `op_done`=1 in EXEC.
- `op_done` outside EXEC is ignored and does not change state or pc.
- `op_done` held high for multiple cycles: only the EXEC-cycle sample counts. The next instruction is not affected because the FSM leaves EXEC.

## Timing

- **Reset values:** state=REQ, pc=0, internal opcode/arg registers=0. Outputs: `op_valid`=0, `op_code`/`arg1`/`arg2`=8'h00, `mem_addr`=0, `pc`=0.
- `rst` mid-operation (any state, including EXEC with `op_done`=1) wins. The pc update is discarded.
- **Issue latency,** measured from entering REQ to `op_valid`=1: 2 cycles for len 1, 3 cycles for len 2, 4 cycles for len 3.
- **Post-completion gap:** `op_done` in cycle N causes `op_valid`=0 in N+1 (REQ). The earliest next `op_valid` is N+3.
- **Hold rule:** `op_code`/`arg1`/`arg2` are constant for every cycle of `op_valid`=1.
- **Outputs:** `mem_addr` is combinational. `op_valid`, `pc` and the operand outputs are registered (operands are gated by `op_valid`).

## Test plan

- **Reset:** assert `rst` 2 cycles. All outputs 0. Then first `mem_addr`=0 in REQ. Assert `rst` again in EXEC together with `op_done`: pc returns to 0 and the FSM returns to REQ.
- **Straight line:** memory 02 10 05 60 with `op_done` pulsed one cycle after each `op_valid`.
  - Issues, in order: (02,00,00) at pc 0, (10,05,00) at pc 1, (60,00,00) at pc 3.
  - Latencies 2/3/2 cycles from REQ.
- **3-byte op:** sipush 11 12 34 at pc 4 → `op_code`=11, `arg1`=12, `arg2`=34. Next pc=7.
- **Branch:** goto A7 at pc 8 with `op_done`, `jump`=1, `offset`=16'hFFF8 → next pc=0. Same with `jump`=0 → next pc=11.
- **Stall/hold:** delay `op_done` 10 cycles. `op_valid` stays 1 and the operands are unchanged. Spurious `op_done` pulses during REQ/OP/A1/A2 are ignored (pc unchanged).
- **Wrap:** 1-byte op at pc 16'hFFFF completes → next pc=16'h0000. `jump` with `offset`=+2 from 16'hFFFF → pc=16'h0001.
